// File: rtl/homomorphic_multiply_stream.sv
// homomorphic_multiply_stream
//   Streaming ciphertext-polynomial multiplier. Computes the full linear
//   convolution c = a * b of two length-(DIMENSION+1) coefficient vectors,
//   reducing every coefficient modulo CIPHERTEXT_MODULUS. PARALLEL lanes of
//   coefficients move per beat. Operand A is held in a register and may be
//   reused across products. Operand B is multiply-accumulated as it streams
//   in. The 2*DIMENSION+1 results then drain over a valid/ready stream.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, reuse_a        begin a product (sampled in IDLE only); reuse_a=1 keeps stored A
//   a_valid/a_ready/a_data  A coefficient beats; lane i = coefficient beat*P+i
//   b_valid/b_ready/b_data  B coefficient beats; same lane ordering
//   out_valid/out_ready/out_data/out_last  result beats; lane i = c[beat*P+i]
//   busy                  high whenever the block is not idle
module homomorphic_multiply_stream #(
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int DIMENSION          = 1,
  parameter int PARALLEL           = 1,
  parameter int IDX_WIDTH          = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 reuse_a,
  input  logic                                 a_valid,
  output logic                                 a_ready,
  input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] a_data,
  input  logic                                 b_valid,
  output logic                                 b_ready,
  input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] b_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] out_data,
  output logic                                 out_last,
  output logic                                 busy
);

  localparam int W         = CIPHERTEXT_WIDTH;
  localparam int P         = PARALLEL;
  localparam int N         = DIMENSION + 1;
  localparam int NC        = 2 * DIMENSION + 1;
  localparam int IN_BEATS  = N / P;
  localparam int OUT_BEATS = (NC + P - 1) / P;
  // An accumulator (< 2^W) plus up to P*N products (each < 2^2W) per beat
  // fits in SW bits, so nothing is truncated before the reduction.
  localparam int SW        = 2 * W + $clog2(P * N + 2);
  localparam logic [SW-1:0] MODULUS  = SW'(CIPHERTEXT_MODULUS);
  localparam bit            POW2_MOD = (CIPHERTEXT_MODULUS == (1 << W));

  localparam logic [IDX_WIDTH-1:0] IN_LAST  = IDX_WIDTH'(IN_BEATS - 1);
  localparam logic [IDX_WIDTH-1:0] OUT_LAST = IDX_WIDTH'(OUT_BEATS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_A = 2'd1;
  localparam logic [1:0] S_LOAD_B = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [IDX_WIDTH-1:0] beat_q, beat_d;
  logic [W-1:0]         a_q   [N];
  logic [W-1:0]         a_d   [N];
  logic [W-1:0]         acc_q [NC];
  logic [W-1:0]         acc_d [NC];
  logic [SW-1:0]        sum   [NC];

  // A power-of-two modulus equal to 2^W reduces by plain truncation.
  function automatic logic [W-1:0] reduce(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    if (POW2_MOD) r = v;
    else          r = v % MODULUS;
    return r[W-1:0];
  endfunction

  // Per-index sum of the stored accumulator and every b[x]*a[y] product of
  // the current B beat that lands on that index (k*P + x + y).
  always_comb begin
    for (int i = 0; i < NC; i++) begin
      sum[i] = SW'(acc_q[i]);
      for (int x = 0; x < P; x++) begin
        for (int y = 0; y < N; y++) begin
          if (int'(beat_q) * P + x + y == i)
            sum[i] = sum[i] + SW'(b_data[x*W +: W]) * SW'(a_q[y]);
        end
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    state_d = state_q;
    beat_d  = beat_q;
    a_d     = a_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < NC; i++) acc_d[i] = '0;
          beat_d  = '0;
          state_d = reuse_a ? S_LOAD_B : S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (a_valid) begin
          for (int j = 0; j < N; j++) begin
            for (int x = 0; x < P; x++) begin
              if (int'(beat_q) * P + x == j) a_d[j] = a_data[x*W +: W];
            end
          end
          if (beat_q == IN_LAST) begin
            beat_d  = '0;
            state_d = S_LOAD_B;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        if (b_valid) begin
          // Untouched indices have sum == acc < Q, so reducing them is a no-op.
          for (int i = 0; i < NC; i++) acc_d[i] = reduce(sum[i]);
          if (beat_q == IN_LAST) begin
            beat_d  = '0;
            state_d = S_DRAIN;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (beat_q == OUT_LAST) begin
            beat_d  = '0;
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the A register and accumulators are arrays but still take the
  // asynchronous reset, so a stale product can never leak after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      for (int j = 0; j < N; j++)  a_q[j]   <= '0;
      for (int i = 0; i < NC; i++) acc_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from the
      // same pre-edge values regardless of statement order.
      state_q <= state_d;
      beat_q  <= beat_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
    end
  end

  // Handshake outputs depend only on registered state, never on the
  // partner's valid/ready, and drop at once when reset asserts.
  assign busy      = (state_q != S_IDLE);
  assign a_ready   = (state_q == S_LOAD_A);
  assign b_ready   = (state_q == S_LOAD_B);
  assign out_valid = (state_q == S_DRAIN);
  assign out_last  = out_valid && (beat_q == OUT_LAST);

  // Result lanes past index 2D read as zero; accumulators are frozen during
  // DRAIN so the beat is stable under backpressure.
  always_comb begin
    out_data = '0;
    if (state_q == S_DRAIN) begin
      for (int lane = 0; lane < P; lane++) begin
        for (int i = 0; i < NC; i++) begin
          if (int'(beat_q) * P + lane == i) out_data[lane*W +: W] = acc_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_homomorphic_multiply_stream.sv
// Testbench for homomorphic_multiply_stream. Three instances cover
// (D=1,P=1,Q=1024,W=10), (D=1,P=1,Q=97,W=7) and (D=3,P=2,Q=1024,W=10).
// Expected result beats come from a direct convolution model and are
// queued when the operands are driven; monitors pop them as beats appear.
module tb_homomorphic_multiply_stream;

  typedef int vec_t [4];
  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int conv_at(input vec_t a, input vec_t b, input int n, input int q, input int i);
    longint s = 0;
    for (int x = 0; x < n; x++)
      for (int y = 0; y < n; y++)
        if (x + y == i) s += longint'(a[x]) * longint'(b[y]);
    return int'(s % longint'(q));
  endfunction

  // ---------------- instance 0: D=1, P=1, Q=1024, W=10
  logic start0, reuse0, a_valid0, a_ready0, b_valid0, b_ready0;
  logic out_valid0, out_ready0, out_last0, busy0;
  logic [9:0] a_data0, b_data0, out_data0;
  beat_t q0[$];
  beat_t e0;
  vec_t  a_model0;
  bit    saw_a_ready0;

  homomorphic_multiply_stream #(
    .CIPHERTEXT_WIDTH(10), .CIPHERTEXT_MODULUS(1024), .DIMENSION(1), .PARALLEL(1), .IDX_WIDTH(2)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .reuse_a(reuse0),
    .a_valid(a_valid0), .a_ready(a_ready0), .a_data(a_data0),
    .b_valid(b_valid0), .b_ready(b_ready0), .b_data(b_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .out_last(out_last0), .busy(busy0)
  );

  // ---------------- instance 1: D=1, P=1, Q=97, W=7
  logic start1, reuse1, a_valid1, a_ready1, b_valid1, b_ready1;
  logic out_valid1, out_ready1, out_last1, busy1;
  logic [6:0] a_data1, b_data1, out_data1;
  beat_t q1[$];
  beat_t e1;
  vec_t  a_model1;

  homomorphic_multiply_stream #(
    .CIPHERTEXT_WIDTH(7), .CIPHERTEXT_MODULUS(97), .DIMENSION(1), .PARALLEL(1), .IDX_WIDTH(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .reuse_a(reuse1),
    .a_valid(a_valid1), .a_ready(a_ready1), .a_data(a_data1),
    .b_valid(b_valid1), .b_ready(b_ready1), .b_data(b_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_last(out_last1), .busy(busy1)
  );

  // ---------------- instance 2: D=3, P=2, Q=1024, W=10
  logic start2, reuse2, a_valid2, a_ready2, b_valid2, b_ready2;
  logic out_valid2, out_ready2, out_last2, busy2;
  logic [19:0] a_data2, b_data2, out_data2;
  beat_t q2[$];
  beat_t e2;

  homomorphic_multiply_stream #(
    .CIPHERTEXT_WIDTH(10), .CIPHERTEXT_MODULUS(1024), .DIMENSION(3), .PARALLEL(2), .IDX_WIDTH(3)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .reuse_a(reuse2),
    .a_valid(a_valid2), .a_ready(a_ready2), .a_data(a_data2),
    .b_valid(b_valid2), .b_ready(b_ready2), .b_data(b_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_last(out_last2), .busy(busy2)
  );

  // ---------------- monitors: compare every presented beat with the queue head;
  // the head is popped only when the beat is accepted, so a stalled beat is
  // re-checked each cycle against the same expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_ready0) saw_a_ready0 = 1'b1;
      if (out_valid0) begin
        if (q0.size() == 0) check("u0 unexpected beat (out_valid)", 32'(out_valid0), 32'd0);
        else begin
          e0 = q0[0];
          check("u0 out_data", 32'(out_data0), e0.data);
          check("u0 out_last", 32'(out_last0), 32'(e0.last));
          if (out_ready0) void'(q0.pop_front());
        end
      end
      if (out_valid1) begin
        if (q1.size() == 0) check("u1 unexpected beat (out_valid)", 32'(out_valid1), 32'd0);
        else begin
          e1 = q1[0];
          check("u1 out_data", 32'(out_data1), e1.data);
          check("u1 out_last", 32'(out_last1), 32'(e1.last));
          if (out_ready1) void'(q1.pop_front());
        end
      end
      if (out_valid2) begin
        if (q2.size() == 0) check("u2 unexpected beat (out_valid)", 32'(out_valid2), 32'd0);
        else begin
          e2 = q2[0];
          check("u2 out_data", 32'(out_data2), e2.data);
          check("u2 out_last", 32'(out_last2), 32'(e2.last));
          if (out_ready2) void'(q2.pop_front());
        end
      end
    end
  end

  // ---------------- instance 0 drivers
  task automatic send_a0(input logic [9:0] d);
    bit ok = 1'b0;
    a_valid0 = 1'b1; a_data0 = d;
    for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); ok = a_ready0; end
    check("u0 a_ready wait", 32'(ok), 32'd1);
    @(posedge clk); #1 a_valid0 = 1'b0;
  endtask

  task automatic send_b0(input logic [9:0] d);
    bit ok = 1'b0;
    b_valid0 = 1'b1; b_data0 = d;
    for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); ok = b_ready0; end
    check("u0 b_ready wait", 32'(ok), 32'd1);
    @(posedge clk); #1 b_valid0 = 1'b0;
  endtask

  task automatic product0(input bit reuse, input vec_t a, input vec_t b);
    beat_t e;
    if (!reuse) a_model0 = a;
    for (int j = 0; j < 3; j++) begin
      e.data = 32'(conv_at(a_model0, b, 2, 1024, j));
      e.last = (j == 2);
      q0.push_back(e);
    end
    @(posedge clk); #1 start0 = 1'b1; reuse0 = reuse;
    @(posedge clk); #1 start0 = 1'b0; reuse0 = 1'b0;
    if (!reuse) begin send_a0(10'(a[0])); send_a0(10'(a[1])); end
    send_b0(10'(b[0]));
    send_b0(10'(b[1]));
  endtask

  task automatic wait_first_beat0();
    bit ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); ok = out_valid0; end
    check("u0 out_valid wait", 32'(ok), 32'd1);
  endtask

  task automatic drain0();
    for (int t = 0; t < 100 && q0.size() > 0; t++) @(negedge clk);
    check("u0 drain complete (beats left)", 32'(q0.size()), 32'd0);
    @(negedge clk);
    check("u0 busy after drain", 32'(busy0), 32'd0);
    check("u0 out_valid after drain", 32'(out_valid0), 32'd0);
  endtask

  // ---------------- instance 1 driver
  task automatic product1(input bit reuse, input vec_t a, input vec_t b);
    beat_t e;
    bit ok;
    if (!reuse) a_model1 = a;
    for (int j = 0; j < 3; j++) begin
      e.data = 32'(conv_at(a_model1, b, 2, 97, j));
      e.last = (j == 2);
      q1.push_back(e);
    end
    @(posedge clk); #1 start1 = 1'b1; reuse1 = reuse;
    @(posedge clk); #1 start1 = 1'b0; reuse1 = 1'b0;
    if (!reuse) begin
      for (int k = 0; k < 2; k++) begin
        a_valid1 = 1'b1; a_data1 = 7'(a[k]); ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); ok = a_ready1; end
        check("u1 a_ready wait", 32'(ok), 32'd1);
        @(posedge clk); #1 a_valid1 = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      b_valid1 = 1'b1; b_data1 = 7'(b[k]); ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); ok = b_ready1; end
      check("u1 b_ready wait", 32'(ok), 32'd1);
      @(posedge clk); #1 b_valid1 = 1'b0;
    end
    for (int t = 0; t < 100 && q1.size() > 0; t++) @(negedge clk);
    check("u1 drain complete (beats left)", 32'(q1.size()), 32'd0);
    @(negedge clk);
    check("u1 busy after drain", 32'(busy1), 32'd0);
  endtask

  // ---------------- instance 2 driver (two lanes per beat)
  task automatic product2(input vec_t a, input vec_t b);
    beat_t e;
    bit ok;
    int c [8];
    for (int i = 0; i < 8; i++) c[i] = (i < 7) ? conv_at(a, b, 4, 1024, i) : 0;
    for (int j = 0; j < 4; j++) begin
      e.data = (32'(c[2*j+1]) << 10) | 32'(c[2*j]);
      e.last = (j == 3);
      q2.push_back(e);
    end
    @(posedge clk); #1 start2 = 1'b1; reuse2 = 1'b0;
    @(posedge clk); #1 start2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a_valid2 = 1'b1; a_data2 = {10'(a[2*k+1]), 10'(a[2*k])}; ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); ok = a_ready2; end
      check("u2 a_ready wait", 32'(ok), 32'd1);
      @(posedge clk); #1 a_valid2 = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      b_valid2 = 1'b1; b_data2 = {10'(b[2*k+1]), 10'(b[2*k])}; ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); ok = b_ready2; end
      check("u2 b_ready wait", 32'(ok), 32'd1);
      @(posedge clk); #1 b_valid2 = 1'b0;
    end
    for (int t = 0; t < 100 && q2.size() > 0; t++) @(negedge clk);
    check("u2 drain complete (beats left)", 32'(q2.size()), 32'd0);
    @(negedge clk);
    check("u2 busy after drain", 32'(busy2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    {start0, reuse0, a_valid0, b_valid0} = '0; out_ready0 = 1'b1; a_data0 = '0; b_data0 = '0;
    {start1, reuse1, a_valid1, b_valid1} = '0; out_ready1 = 1'b1; a_data1 = '0; b_data1 = '0;
    {start2, reuse2, a_valid2, b_valid2} = '0; out_ready2 = 1'b1; a_data2 = '0; b_data2 = '0;
    a_model0 = '{0, 0, 0, 0};
    a_model1 = '{0, 0, 0, 0};
    saw_a_ready0 = 1'b0;

    // Reset state
    #12;
    check("reset busy",      32'(busy0),      32'd0);
    check("reset a_ready",   32'(a_ready0),   32'd0);
    check("reset b_ready",   32'(b_ready0),   32'd0);
    check("reset out_valid", 32'(out_valid0), 32'd0);
    check("reset out_last",  32'(out_last0),  32'd0);
    check("reset out_data",  32'(out_data0),  32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Basic product with a 5-cycle stall after the first result beat
    product0(1'b0, '{3, 5, 0, 0}, '{2, 7, 0, 0});
    wait_first_beat0();
    @(posedge clk); #1 out_ready0 = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("stall out_valid held", 32'(out_valid0), 32'd1);
    end
    @(posedge clk); #1 out_ready0 = 1'b1;
    drain0();

    // Reuse stored A; a start pulse during DRAIN must be ignored
    saw_a_ready0 = 1'b0;
    product0(1'b1, '{0, 0, 0, 0}, '{1, 0, 0, 0});
    wait_first_beat0();
    @(posedge clk); #1 out_ready0 = 1'b0; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(posedge clk); #1 out_ready0 = 1'b1;
    drain0();
    repeat (3) @(negedge clk);
    check("start in DRAIN ignored (busy)", 32'(busy0), 32'd0);
    check("reuse never raised a_ready", 32'(saw_a_ready0), 32'd0);

    // Modular wrap at Q = 2^W
    product0(1'b0, '{1000, 1000, 0, 0}, '{1000, 1000, 0, 0});
    drain0();

    // Asynchronous reset in the middle of LOAD_B
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    send_a0(10'd3);
    send_a0(10'd5);
    b_valid0 = 1'b1; b_data0 = 10'd2;
    @(negedge clk);
    check("pre-reset b_ready", 32'(b_ready0), 32'd1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("async reset busy",      32'(busy0),      32'd0);
    check("async reset b_ready",   32'(b_ready0),   32'd0);
    check("async reset out_valid", 32'(out_valid0), 32'd0);
    b_valid0 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post-reset idle", 32'(busy0), 32'd0);
    product0(1'b0, '{3, 5, 0, 0}, '{2, 7, 0, 0});
    drain0();

    // Instance 1: reuse straight after reset uses A = 0, then Q = 97 wrap
    product1(1'b1, '{0, 0, 0, 0}, '{5, 6, 0, 0});
    product1(1'b0, '{50, 60, 0, 0}, '{40, 30, 0, 0});

    // Instance 2: intra-beat collisions with two lanes
    product2('{1, 2, 3, 4}, '{1, 1, 1, 1});
    product2('{1000, 7, 1023, 512}, '{999, 3, 1000, 2});

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/homomorphic_multiply_stream.md
Name: homomorphic_multiply_stream

Overview:
Streaming, parametrised ciphertext-polynomial multiplier for the encrypted-compute datapath. It computes the full linear convolution of two length-(DIMENSION+1) coefficient vectors modulo CIPHERTEXT_MODULUS, taking PARALLEL coefficients per beat. Operand A is loaded into a coefficient register and can be reused across products. Operand B is streamed and multiply-accumulated. The 2*DIMENSION+1 results are drained over a valid/ready stream to the downstream relinearisation/output stage.

Parameters:
CIPHERTEXT_WIDTH, 10, coefficient width W.
CIPHERTEXT_MODULUS, 1024, modulus Q; 2 <= Q <= 2^W; need not be a power of two.
DIMENSION, 1, polynomial degree D; the vector length is N = D+1.
PARALLEL, 1, lanes per beat P; N must be divisible by P.
IDX_WIDTH, 2, index width; must cover 0..2*D.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a new product; sampled only in IDLE
reuse_a  in  1  sampled with start; 1 = skip LOAD_A and keep the stored A
a_valid  in  1  A beat valid
a_ready  out  1  A beat accepted
a_data  in  P*W  A coefficients; lane i holds coefficient beat*P+i
b_valid  in  1  B beat valid
b_ready  out  1  B beat accepted
b_data  in  P*W  B coefficients; same lane ordering as a_data
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts the result beat
out_data  out  P*W  result coefficients; lane i holds c[beat*P+i]
out_last  out  1  final result beat
busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, LOAD_A, LOAD_B, DRAIN. A handshake is valid&&ready on a rising edge of clk.
- Reset (asynchronous, rst_n low):
  - state = IDLE; all accumulators = 0; the A register = 0; beat counters = 0.
  - a_ready, b_ready, out_valid, out_last and busy go to 0 immediately.
  - out_data = 0.
  - Reset mid-operation abandons the product. No partial output is emitted.
- IDLE:
  - start=1 clears all 2D+1 accumulators.
  - It then moves to LOAD_A if reuse_a=0, otherwise to LOAD_B.
  - reuse_a=1 directly after reset uses A = all zeros.
- LOAD_A:
  - a_ready=1. Each handshake writes P coefficients at positions beat*P..beat*P+P-1.
  - After N/P handshakes, moves to LOAD_B on the next cycle.
  - b_data and b_valid are ignored in this state.
- LOAD_B:
  - b_ready=1. For beat k, every lane x and every y in 0..D contributes b[x]*a[y] to index k*P+x+y.
  - All contributions landing on the same index in one beat are summed.
  - Update rule: acc[i] <= (acc[i] + sum of contributions) mod Q. No contribution may be lost.
  - Internal sums must be wide enough that no intermediate truncation occurs before the mod.
  - When Q == 2^W, the reduction is truncation.
  - Inputs >= Q are legal; the result is still mod Q.
  - After N/P handshakes, moves to DRAIN. out_valid rises in the cycle after the last B handshake (1-cycle latency).
- DRAIN:
  - There are R = ceil((2D+1)/P) beats. Beat j presents c[j*P+lane] on out_data.
  - Lanes whose index exceeds 2D output 0.
  - out_data, out_valid and out_last stay stable while out_valid && !out_ready.
  - out_last=1 only on beat R-1. Its handshake returns the block to IDLE.
  - busy drops in the cycle after the final handshake.
- start while busy is ignored; a_valid/b_valid outside their states are ignored.
- The A register persists across products until it is reloaded or reset.
- Handshake rules:
  - ready signals do not depend combinationally on the valid signals.
  - valid signals do not depend combinationally on the ready signals.

Test Plan:
- D=1,P=1,Q=1024,W=10; A=[3,5], B=[2,7] -> out beats 6, 31, 35; out_last only with 35; busy low afterwards.
- Modular wrap, Q=1024; A=[1000,1000], B=[1000,1000] -> 576, 128, 576. Same with Q=97,W=7; A=[50,60], B=[40,30] -> 60, 20, 54.
- Intra-beat collisions, D=3,P=2; A=[1,2,3,4], B=[1,1,1,1] -> beats (1,3), (6,10), (9,7), (4,0); out_last on the 4th beat.
- Backpressure: hold out_ready=0 for 5 cycles during DRAIN -> out_valid stays 1 and out_data is unchanged; the stall never causes a beat to be duplicated or skipped.
- Reuse: after the first test, start with reuse_a=1 and B=[1,0] -> a_ready never rises; out = 3, 5, 0. A start pulse during DRAIN is ignored.
- Reset: drop rst_n mid-LOAD_B (asynchronously, between edges) -> busy, b_ready and out_valid fall immediately. A new product with A=[3,5], B=[2,7] then yields 6, 31, 35.
